// File: rtl/universal_register_if.sv
// Bundles the universal register's control, data and status signals.
// The master drives the operation inputs and the slave drives the registered outputs.
interface universal_register_if #(
    parameter int BITS = 4
);
    localparam int CW = $clog2(BITS);

    logic            enb;
    logic [1:0]      MODO;
    logic            S_IN;
    logic [BITS-1:0] D;
    logic [BITS-1:0] Q;
    logic            S_OUT;
    logic [CW-1:0]   cnt;
    logic            word_done;

    modport master (
        output enb, MODO, S_IN, D,
        input  Q, S_OUT, cnt, word_done
    );

    modport slave (
        input  enb, MODO, S_IN, D,
        output Q, S_OUT, cnt, word_done
    );
endinterface

// File: rtl/universal_register.sv
// Universal shift register: shift left/right, parallel load or hold, with a shift counter and word_done pulse.
// Latency: one clk edge from sampled inputs to Q/S_OUT/cnt/word_done; all outputs are registered.
// Backpressure: none; enb=0 freezes the register like a gated clock and only clears word_done.
module universal_register #(
    parameter int BITS = 4
) (
    input logic              clk,
    input logic              reset,
    universal_register_if.slave bus
);
    localparam int CW = $clog2(BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(BITS - 1);

    typedef enum logic [1:0] {
        SHL  = 2'b00,
        SHR  = 2'b01,
        LOAD = 2'b10,
        HOLD = 2'b11
    } mode_e;

    logic [BITS-1:0] q_r;
    logic            so_r;
    logic [CW-1:0]   cnt_r;
    logic            wd_r;
    logic            cnt_wrap;
    logic [CW-1:0]   cnt_nxt;

    // cnt counts modulo BITS, so the wrap point is BITS-1 even when BITS is not a power of two
    assign cnt_wrap = (cnt_r == CNT_LAST);
    assign cnt_nxt  = cnt_wrap ? '0 : cnt_r + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r   <= '0;
            so_r  <= 1'b0;
            cnt_r <= '0;
            wd_r  <= 1'b0;
        end else if (bus.enb) begin
            case (mode_e'(bus.MODO))
                SHL: begin
                    q_r   <= {q_r[BITS-2:0], bus.S_IN};
                    so_r  <= q_r[BITS-1];
                    cnt_r <= cnt_nxt;
                    wd_r  <= cnt_wrap;
                end
                SHR: begin
                    q_r   <= {bus.S_IN, q_r[BITS-1:1]};
                    so_r  <= q_r[0];
                    cnt_r <= cnt_nxt;
                    wd_r  <= cnt_wrap;
                end
                LOAD: begin
                    q_r   <= bus.D;
                    so_r  <= 1'b0;
                    cnt_r <= '0;
                    wd_r  <= 1'b0;
                end
                default: begin
                    wd_r  <= 1'b0;
                end
            endcase
        end else begin
            wd_r <= 1'b0;
        end
    end

    assign bus.Q         = q_r;
    assign bus.S_OUT     = so_r;
    assign bus.cnt       = cnt_r;
    assign bus.word_done = wd_r;
endmodule

// File: doc/universal_register.md
UNIVERSAL_REGISTER -- requirements
Module: universal_register

Interface
REQ-001 Parameter: BITS, default 4, register width in bits (minimum 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 enb  input  1  register enable; enb=0 is equivalent to a gated-off clock from the upstream enabler stage.
REQ-005 MODO  input  2  operation select: 00 shift left, 01 shift right, 10 parallel load, 11 hold.
REQ-006 S_IN  input  1  serial input bit.
REQ-007 D  input  BITS  parallel load data.
REQ-008 Q  output  BITS  register contents, registered.
REQ-009 S_OUT  output  1  serial output bit, registered.
REQ-010 cnt  output  clog2(BITS)  count of shifts since the last load or wrap, registered.
REQ-011 word_done  output  1  one-cycle pulse marking completion of BITS shifts, registered.

Function
REQ-012 Update rule: all outputs update only on a rising clk edge with enb=1 and reset=0.
REQ-013 enb=0: Q, S_OUT and cnt SHALL hold their values, and word_done SHALL be 0 after the edge.
REQ-014 MODO=00, shift left: Q <= {Q[BITS-2:0], S_IN}, S_OUT <= Q[BITS-1].
REQ-015 MODO=01, shift right: Q <= {S_IN, Q[BITS-1:1]}, S_OUT <= Q[0].
REQ-016 MODO=10, parallel load: Q <= D, S_OUT <= 0, cnt <= 0, word_done <= 0.
REQ-017 MODO=11, hold: Q, S_OUT and cnt SHALL hold, and word_done <= 0.
REQ-018 Shift count: each shift (MODO 00 or 01) SHALL increment cnt modulo BITS.
REQ-019 Direction change: changing shift direction SHALL NOT clear cnt.
REQ-020 word_done assertion: on the edge where cnt wraps from BITS-1 to 0, word_done SHALL be 1 for exactly that cycle.
REQ-021 word_done deassertion: on every other enabled edge, word_done SHALL be 0.
REQ-022 Consecutive words: back-to-back shifting with no gap SHALL produce one word_done pulse every BITS shifts.
REQ-023 Latency: any enabled operation SHALL be visible on Q/S_OUT one edge after MODO/D/S_IN are sampled; there is no combinational path from inputs to outputs.
REQ-024 enb toggling: toggling enb mid-word SHALL pause the shift sequence without losing cnt; shifting resumes from the held cnt.
REQ-025 Undefined MODO: X/Z on MODO SHALL NOT be required to behave; the bench drives only legal values.

Reset
REQ-026 Reset values: reset=1 SHALL force Q=0, S_OUT=0, cnt=0, word_done=0 immediately, independent of clk and enb.
REQ-027 Reset hold: while reset=1, all outputs SHALL remain at reset values regardless of enb or MODO.
REQ-028 Reset release: after reset deasserts, the first enabled rising edge SHALL perform a normal operation.
REQ-029 Reset mid-word: reset during a partial shift sequence SHALL discard cnt progress, and no word_done pulse SHALL follow.

Verification (BITS=4)
REQ-030 Bench: the bench SHALL cover at least the following directed scenarios.
REQ-031 Load: reset, then MODO=10, D=1011, enb=1 for one edge -> Q=1011, S_OUT=0, cnt=0, word_done=0.
REQ-032 Left shift word: from Q=1011, MODO=00, S_IN=0 for 4 edges -> Q=0110,1100,1000,0000; S_OUT=1,0,1,1; cnt=1,2,3,0; word_done=1 only after the 4th edge.
REQ-033 Right shift: from Q=1011, MODO=01, S_IN=1 for one edge -> Q=1101, S_OUT=1, cnt=1.
REQ-034 Disable and hold: from Q=1011, cnt=2, enb=0 with MODO=00 for 3 edges, then enb=1 with MODO=11 for 2 edges -> Q=1011 and cnt=2 throughout, word_done=0.
REQ-035 Async reset: reset=1 asserted between clk edges after 2 shifts -> Q=0000, S_OUT=0, cnt=0 before the next edge; after release, 4 shifts are needed before word_done.
REQ-036 Pause mid-word: shift 2, enb=0 for 2 edges, shift 2 more -> word_done pulses exactly once, on the 4th shift edge.
